multi_timer: RTL and testbench

//   Parametrised multi-channel timer/counter on the CPU bridge word bus; successor to the single-channel TC.
//   NUM_CH independent down-counters, each with one-shot or auto-reload mode, an 8-bit prescaler and an IRQ mask.

---
 rtl/multi_timer.sv | 174 +++++++++++++++++
 tb/tb_multi_timer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// Multi-channel down-counting timer on the CPU bridge word bus.
// Each channel has one-shot/auto-reload modes, a prescaler, an IRQ mask and a sticky W1C pending flag.
module multi_timer #(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 32,
  parameter bit PSC_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:2]       Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic              IRQ,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_INT  = 2'd3;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam logic [5:0]       STATUS_IDX = 6'd63;
  localparam int               MAP_LIMIT  = 4 * NUM_CH;
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  logic [5:0] idx;
  logic [3:0] ch_idx;
  logic [1:0] reg_idx;
  logic       ch_mapped;
  logic       status_hit;
  logic       unused_bits;

  logic             en      [NUM_CH];
  logic [1:0]       mode    [NUM_CH];
  logic             im      [NUM_CH];
  logic [7:0]       psc_cfg [NUM_CH];
  logic [WIDTH-1:0] preset  [NUM_CH];
  logic [WIDTH-1:0] count   [NUM_CH];
  logic [7:0]       psc_cnt [NUM_CH];
  logic [1:0]       state   [NUM_CH];

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] ch_wr;
  logic [NUM_CH-1:0] ctrl_clr;
  logic [NUM_CH-1:0] status_clr;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] set_pend;

  assign idx         = Addr[7:2];
  assign ch_idx      = idx[5:2];
  assign reg_idx     = idx[1:0];
  assign ch_mapped   = ({26'd0, idx} < 32'(MAP_LIMIT));
  assign status_hit  = (idx == STATUS_IDX);
  assign unused_bits = ^{Addr[31:8], Din};
  assign status_clr  = (WE && status_hit) ? Din[NUM_CH-1:0] : '0;

  // A bus write to any register of a channel freezes that channel's FSM for the cycle.
  always_comb begin
    ch_wr    = '0;
    ctrl_clr = '0;
    tick     = '0;
    set_pend = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_wr[c]    = WE && ch_mapped && (ch_idx == 4'(c));
      ctrl_clr[c] = ch_wr[c] && (reg_idx == REG_CTRL);
      tick[c]     = (psc_cnt[c] == (PSC_EN ? psc_cfg[c] : 8'd0));
      set_pend[c] = !ch_wr[c] && (state[c] == S_CNT) && en[c] && tick[c]
                    && !(count[c] > ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        en[c]      <= 1'b0;
        mode[c]    <= 2'b00;
        im[c]      <= 1'b0;
        psc_cfg[c] <= 8'd0;
        preset[c]  <= '0;
        count[c]   <= '0;
        psc_cnt[c] <= 8'd0;
        state[c]   <= S_IDLE;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_wr[c]) begin
          case (reg_idx)
            REG_CTRL: begin
              en[c]   <= Din[0];
              mode[c] <= Din[2:1];
              im[c]   <= Din[3];
              if (PSC_EN) psc_cfg[c] <= Din[15:8];
            end
            REG_PRESET: preset[c] <= Din[WIDTH-1:0];
            default: ;
          endcase
        end else begin
          case (state[c])
            S_IDLE: if (en[c]) state[c] <= S_LOAD;
            S_LOAD: begin
              count[c]   <= preset[c];
              psc_cnt[c] <= 8'd0;
              state[c]   <= S_CNT;
            end
            S_CNT: begin
              if (!en[c]) begin
                state[c] <= S_IDLE;
              end else if (tick[c]) begin
                psc_cnt[c] <= 8'd0;
                if (count[c] > ONE) begin
                  count[c] <= count[c] - ONE;
                end else begin
                  count[c] <= '0;
                  state[c] <= S_INT;
                end
              end else begin
                psc_cnt[c] <= psc_cnt[c] + 8'd1;
              end
            end
            default: begin
              // Only mode 01 reloads; the other encodings behave as one-shot.
              if (mode[c] == 2'b01) begin
                state[c] <= S_LOAD;
              end else begin
                en[c]    <= 1'b0;
                state[c] <= S_IDLE;
              end
            end
          endcase
        end
      end
    end
  end

  // A channel setting its flag beats a simultaneous STATUS write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~status_clr & ~ctrl_clr) | set_pend;
    end
  end

  always_comb begin
    Dout = '0;
    if (status_hit) begin
      Dout[NUM_CH-1:0] = pending;
    end else if (ch_mapped) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_idx == 4'(c)) begin
          case (reg_idx)
            REG_CTRL:   Dout = {16'd0, psc_cfg[c], 4'd0, im[c], mode[c], en[c]};
            REG_PRESET: Dout[WIDTH-1:0] = preset[c];
            REG_COUNT:  Dout[WIDTH-1:0] = count[c];
            default:    Dout = '0;
          endcase
        end
      end
    end
  end

  always_comb begin
    irq_vec = '0;
    for (int c = 0; c < NUM_CH; c++) irq_vec[c] = pending[c] & im[c];
  end

  assign IRQ = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Randomized bench for multi_timer; the reference derives COUNT and pending from
// each channel's elapsed unfrozen cycles using the timer's period arithmetic.
module tb_multi_timer;

  localparam int NUM_CH     = 2;
  localparam int STATUS_IDX = 63;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:2]       Addr;
  logic              WE;
  logic [31:0]       Din;
  logic [31:0]       Dout;
  logic              IRQ;
  logic [NUM_CH-1:0] irq_vec;

  int checks = 0;
  int errors = 0;

  multi_timer #(.NUM_CH(NUM_CH), .WIDTH(32), .PSC_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .IRQ(IRQ), .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic we, input logic [31:0] din);
    Addr      = '0;
    Addr[7:2] = 6'(idx);
    WE        = we;
    Din       = din;
  endtask

  task automatic readReg(input int idx, output logic [31:0] val);
    applyStimulus(idx, 1'b0, 32'd0);
    #1;
    val = Dout;
  endtask

  task automatic writeReg(input int idx, input logic [31:0] data);
    @(negedge clk);
    applyStimulus(idx, 1'b1, data);
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    WE    = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One channel runs from reset; other bus traffic is injected around it.
  task automatic runScenario(input int ch, input int preset, input int psc, input int mode,
                             input bit im, input int ncyc, input bit busy, input bit race);
    int other, n, q, period, kEff, idx, kind, m, expCount;
    bit autoRel, expPend, we, frozen, setNow, expEn;
    logic [31:0] otherPreset, ctrlWord, v, din;
    logic [NUM_CH-1:0] expVec;
    other       = (ch + 1) % NUM_CH;
    n           = (preset < 1) ? 1 : preset;
    q           = psc + 1;
    period      = n * q + 2;
    autoRel     = (mode == 1);
    kEff        = 0;
    expPend     = 1'b0;
    otherPreset = 32'd0;
    doReset();
    writeReg(ch * 4 + 1, 32'(preset));
    ctrlWord        = $urandom();
    ctrlWord[0]     = 1'b1;
    ctrlWord[2:1]   = 2'(mode);
    ctrlWord[3]     = im;
    ctrlWord[15:8]  = 8'(psc);
    writeReg(ch * 4, ctrlWord);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      idx = STATUS_IDX;
      we  = 1'b0;
      din = 32'd0;
      if (race && kEff == period - 1) begin
        we  = 1'b1;
        din = 32'(1) << ch;
      end else if (busy) begin
        kind = $urandom_range(0, 9);
        case (kind)
          0, 1: begin we = 1'b1; din = $urandom(); end
          2, 3: begin we = 1'b1; idx = other * 4 + 1; din = $urandom(); end
          4:    begin we = 1'b1; idx = ch * 4 + 2; din = $urandom(); end
          5:    begin we = 1'b1; idx = ch * 4 + 3; din = $urandom(); end
          6:    begin we = 1'b1; idx = $urandom_range(4 * NUM_CH, 62); din = $urandom(); end
          default: ;
        endcase
      end
      applyStimulus(idx, we, din);
      @(posedge clk);
      #1;
      WE = 1'b0;

      frozen = we && (idx < 4 * NUM_CH) && (idx / 4 == ch);
      setNow = 1'b0;
      if (!frozen) begin
        kEff++;
        setNow = (kEff % period == 0) && (autoRel || kEff == period);
      end
      if (setNow) expPend = 1'b1;
      else if (we && idx == STATUS_IDX && din[ch]) expPend = 1'b0;
      if (we && idx == other * 4 + 1) otherPreset = din;

      if (kEff == 0 || (!autoRel && kEff > period)) begin
        expCount = 0;
      end else begin
        m = ((kEff - 1) % period) + 1;
        expCount = (m == 1 || m == period) ? 0 : preset - (m - 2) / q;
      end
      expEn = autoRel || (kEff <= period);
      expVec = '0;
      expVec[ch] = expPend & im;

      readReg(ch * 4 + 2, v);
      checkOutput($sformatf("count ch%0d k%0d", ch, k), v, 32'(expCount));
      readReg(STATUS_IDX, v);
      checkOutput($sformatf("status ch%0d k%0d", ch, k), v, 32'(expPend) << ch);
      readReg(ch * 4, v);
      checkOutput($sformatf("ctrl ch%0d k%0d", ch, k), v,
                  {16'h0, 8'(psc), 4'h0, im, 2'(mode), expEn});
      checkOutput($sformatf("irq k%0d", k), {31'd0, IRQ}, {31'd0, expPend & im});
      checkOutput($sformatf("irq_vec k%0d", k), 32'(irq_vec), 32'(expVec));
    end
    readReg(other * 4 + 1, v);
    checkOutput($sformatf("preset ch%0d", other), v, otherPreset);
    readReg(other * 4 + 2, v);
    checkOutput($sformatf("idle count ch%0d", other), v, 32'd0);
  endtask

  task automatic resetMidCount();
    logic [31:0] v;
    doReset();
    writeReg(5, 32'd0);
    writeReg(4, 32'h9);
    writeReg(1, 32'd5);
    writeReg(0, 32'h9);
    repeat (4) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    readReg(2, v);
    checkOutput("mid count ch0", v, 32'd3);
    readReg(STATUS_IDX, v);
    checkOutput("mid status", v, 32'h2);
    checkOutput("mid irq", {31'd0, IRQ}, 32'd1);
    readReg(3, v);
    checkOutput("rsvd read", v, 32'd0);
    readReg(8, v);
    checkOutput("unmapped 8", v, 32'd0);
    readReg(62, v);
    checkOutput("unmapped 62", v, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    readReg(0, v);
    checkOutput("rst ctrl0", v, 32'd0);
    readReg(1, v);
    checkOutput("rst preset0", v, 32'd0);
    readReg(2, v);
    checkOutput("rst count0", v, 32'd0);
    readReg(STATUS_IDX, v);
    checkOutput("rst status", v, 32'd0);
    checkOutput("rst irq", {31'd0, IRQ}, 32'd0);
    checkOutput("rst irq_vec", 32'(irq_vec), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = '0;
    Din   = '0;
    repeat (2) @(posedge clk);
    #1;
    readReg(0, v);
    checkOutput("reset ctrl0", v, 32'd0);
    readReg(STATUS_IDX, v);
    checkOutput("reset status", v, 32'd0);
    checkOutput("reset irq", {31'd0, IRQ}, 32'd0);
    reset = 1'b0;

    runScenario(0, 5, 0, 0, 1'b1, 12, 1'b0, 1'b0);
    runScenario(1, 3, 0, 1, 1'b1, 16, 1'b0, 1'b0);
    runScenario(0, 2, 3, 0, 1'b1, 16, 1'b0, 1'b0);
    runScenario(0, 4, 0, 0, 1'b0, 10, 1'b0, 1'b1);
    runScenario(1, 0, 0, 1, 1'b1, 10, 1'b0, 1'b1);
    runScenario(0, 5, 0, 1, 1'b1, 24, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      int p, s, md;
      p  = $urandom_range(0, 6);
      s  = $urandom_range(0, 3);
      md = $urandom_range(0, 3);
      runScenario($urandom_range(0, NUM_CH - 1), p, s, md, 1'($urandom_range(0, 1)),
                  2 * ((p < 1 ? 1 : p) * (s + 1) + 2) + 6,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    resetMidCount();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
